bus_arbiter: RTL and testbench

Round-robin arbiter that shares one system-bus leader port between several bus leaders (e.g. a core and a DMA/sequencer) ahead of `system_bus`. Forwards one winning request per cycle, holds ownership across a read until `read_data_valid` returns, and routes read data back only to the issuing leader. A read timeout returns an error word, so a silent follower cannot deadlock the bus.

---
 rtl/bus_arbiter_pkg.sv | 37 +++
 rtl/bus_arbiter_rr_picker.sv | 35 +++
 rtl/bus_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin system-bus arbiter.
//   bus_req_t : leader -> follower request payload (addr, read/write strobes, byte enables, write data)
//   bus_rsp_t : follower -> leader read response (read data + valid)
package bus_arbiter_pkg;

  localparam int unsigned AddrW          = 32;
  localparam int unsigned DataW          = 32;
  localparam int unsigned BeW            = 4;
  localparam int unsigned TimeoutDefault = 64;

  // Returned to the owning leader when a read times out
  localparam logic [DataW-1:0] ErrorData = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE,
    READ_WAIT
  } state_t;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             read_req;
    logic             write_req;
    logic [BeW-1:0]   byte_enable;
    logic [DataW-1:0] write_data;
  } bus_req_t;

  typedef struct packed {
    logic [DataW-1:0] read_data;
    logic             read_data_valid;
  } bus_rsp_t;

  // Index increment that wraps at n
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : one request bit per leader
//   ptr   : first index to consider; the search wraps modulo Leaders
//   found : at least one request is present
//   idx   : first requesting index at or after ptr
module rr_picker #(
  parameter  int unsigned Leaders = 2,
  localparam int unsigned IdxW    = $clog2(Leaders)
) (
  input  logic [Leaders-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic               found,
  output logic [IdxW-1:0]    idx
);

  int unsigned cand;

  // Walk the ring starting at ptr; first hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < Leaders; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= Leaders) begin
        cand = cand - Leaders;
      end
      if (!found && req[IdxW'(cand)]) begin
        found = 1'b1;
        idx   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system-bus leader port among several leaders.
// Holds the bus across a read until the follower returns data or the read times out.
//   clk, reset    : clock, synchronous active-high reset
//   leader_req[i] : request payload from leader i (held until grant[i])
//   leader_rsp[i] : read response routed back to leader i (only the read owner sees data)
//   follower_req  : request forwarded to the system bus
//   follower_rsp  : read response from the system bus
//   grant         : one-hot, combinational acceptance of a leader request
//   timeout_err   : one-cycle pulse when a read is aborted by timeout
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned Leaders = 2,
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  bus_req_t           leader_req [Leaders],
  output bus_rsp_t           leader_rsp [Leaders],
  output bus_req_t           follower_req,
  input  bus_rsp_t           follower_rsp,
  output logic [Leaders-1:0] grant,
  output logic               timeout_err
);

  localparam int unsigned IdxW = $clog2(Leaders);
  localparam int unsigned CntW = $clog2(Timeout);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [Leaders-1:0] req_vec;
  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;
  bus_req_t           sel;

  // Any transfer request counts for arbitration
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < Leaders; i++) begin
      req_vec[i] = leader_req[i].read_req | leader_req[i].write_req;
    end
  end

  rr_picker #(
    .Leaders(Leaders)
  ) u_picker (
    .req  (req_vec),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state, request mux and response demux; everything quiet while in reset
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    sel          = '0;
    follower_req = '0;
    grant        = '0;
    timeout_err  = 1'b0;
    for (int i = 0; i < Leaders; i++) begin
      leader_rsp[i] = '0;
    end

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          for (int i = 0; i < Leaders; i++) begin
            if (pick_found && (pick_idx == IdxW'(i))) begin
              grant[i] = 1'b1;
              sel      = leader_req[i];
            end
          end
          follower_req = sel;
          // A simultaneous read+write is served as a plain write
          if (sel.write_req) begin
            follower_req.read_req = 1'b0;
          end
          if (pick_found) begin
            rr_ptr_d = IdxW'(wrap_inc(32'(pick_idx), Leaders));
          end
          if (sel.read_req && !sel.write_req) begin
            owner_d = pick_idx;
            cnt_d   = '0;
            state_d = READ_WAIT;
          end
        end

        READ_WAIT: begin
          if (follower_rsp.read_data_valid) begin
            for (int i = 0; i < Leaders; i++) begin
              if (owner_q == IdxW'(i)) begin
                leader_rsp[i] = follower_rsp;
              end
            end
            state_d = IDLE;
          end else if (cnt_q == CntW'(Timeout - 1)) begin
            for (int i = 0; i < Leaders; i++) begin
              if (owner_q == IdxW'(i)) begin
                leader_rsp[i].read_data       = ErrorData;
                leader_rsp[i].read_data_valid = 1'b1;
              end
            end
            timeout_err = 1'b1;
            state_d     = IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: the stimulus process drives leaders and a
// follower with random latency, predicts transfers/responses with a ring-order model and
// queues them; a negedge monitor matches DUT activity against those queues.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int L    = 3;
  localparam int TO   = 4;
  localparam int NCYC = 3000;

  typedef struct {
    int       cyc;
    int       ldr;
    bus_req_t req;
  } xfer_t;

  typedef struct {
    int          cyc;
    int          ldr;
    logic [31:0] data;
    logic        to;
  } rsp_t;

  logic         clk;
  logic         reset;
  bus_req_t     leader_req [L];
  bus_rsp_t     leader_rsp [L];
  bus_req_t     follower_req;
  bus_rsp_t     follower_rsp;
  logic [L-1:0] grant;
  logic         timeout_err;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    cyc;
  int    ncmp;
  int    nerr;

  bus_arbiter #(
    .Leaders(L),
    .Timeout(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .leader_req  (leader_req),
    .leader_rsp  (leader_rsp),
    .follower_req(follower_req),
    .follower_rsp(follower_rsp),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string act, input string exp);
    ncmp++;
    nerr++;
    $display("FAIL %s at cycle %0d: actual %s, required %s", name, cyc, act, exp);
  endtask

  function automatic bus_req_t mk_req(input logic rd, input logic wr, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] be);
    bus_req_t r;
    r.addr        = a;
    r.read_req    = rd;
    r.write_req   = wr;
    r.byte_enable = be;
    r.write_data  = d;
    return r;
  endfunction

  // Monitor: match DUT activity on the falling edge against the queued predictions
  logic [L-1:0] mon_vld;
  xfer_t        mon_x;
  rsp_t         mon_r;

  always @(negedge clk) begin
    while (xq.size() > 0 && xq[0].cyc < cyc) begin
      note_fail("xfer_missing", "no transfer", $sformatf("grant to leader %0d", xq[0].ldr));
      void'(xq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      note_fail("rsp_missing", "no response", $sformatf("valid to leader %0d", rq[0].ldr));
      void'(rq.pop_front());
    end

    for (int i = 0; i < L; i++) begin
      mon_vld[i] = leader_rsp[i].read_data_valid;
    end

    if (reset) begin
      chk("reset_grant", 128'(grant), 128'(0));
      chk("reset_follower_req", 128'({follower_req.read_req, follower_req.write_req}), 128'(0));
      chk("reset_leader_valid", 128'(mon_vld), 128'(0));
    end

    if (grant != '0 || follower_req.read_req || follower_req.write_req) begin
      if (xq.size() > 0 && xq[0].cyc == cyc) begin
        mon_x = xq.pop_front();
        chk("grant", 128'(grant), 128'(L'(1) << mon_x.ldr));
        chk("follower_req", 128'(follower_req), 128'(mon_x.req));
      end else begin
        note_fail("xfer_unexpected", $sformatf("grant %b", grant), "no transfer");
      end
    end

    if (mon_vld != '0 || timeout_err) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        mon_r = rq.pop_front();
        chk("rsp_valid", 128'(mon_vld), 128'(L'(1) << mon_r.ldr));
        chk("rsp_data", 128'(leader_rsp[mon_r.ldr].read_data), 128'(mon_r.data));
        chk("timeout_err", 128'(timeout_err), 128'(mon_r.to));
        for (int i = 0; i < L; i++) begin
          if (i != mon_r.ldr) begin
            chk("nonowner_data", 128'(leader_rsp[i].read_data), 128'(0));
          end
        end
      end else begin
        note_fail("rsp_unexpected", $sformatf("valid %b timeout_err %b", mon_vld, timeout_err),
                  "no response");
      end
    end
  end

  // Stimulus and reference model
  bus_req_t pend [L];
  bit       has  [L];
  int       nxt;
  bit       busy;
  int       owner;
  int       waited;
  int       lat;
  bit       rst_now;
  int       w;
  int       j;
  int       kind;
  bus_req_t e;

  initial begin
    ncmp         = 0;
    nerr         = 0;
    cyc          = 0;
    reset        = 1'b1;
    follower_rsp = '0;
    nxt          = 0;
    busy         = 1'b0;
    owner        = 0;
    waited       = 0;
    lat          = 0;
    for (int i = 0; i < L; i++) begin
      leader_req[i] = '0;
      has[i]        = 1'b0;
      pend[i]       = '0;
    end
    // Leaders 0 and 1 request before and during reset
    for (int i = 0; i < 2; i++) begin
      has[i]  = 1'b1;
      pend[i] = mk_req(1'b0, 1'b1, 32'h3000_0000 + 32'(i), 32'(i + 10), 4'hF);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      rst_now = (c < 3) || (busy && $urandom_range(0, 30) == 0);

      // New requests: a short two-leader write stream, then random traffic
      for (int i = 0; i < L; i++) begin
        if (!has[i]) begin
          if (c >= 3 && c < 15) begin
            if (i < 2) begin
              has[i]  = 1'b1;
              pend[i] = mk_req(1'b0, 1'b1, 32'h1000_0000, 32'(i + 1), 4'hF);
            end
          end else if (c >= 15 && $urandom_range(0, 9) < 4) begin
            kind    = int'($urandom_range(0, 3));
            has[i]  = 1'b1;
            pend[i] = mk_req(kind == 1 || kind == 2 || kind == 3, kind == 0 || kind == 3,
                             $urandom, $urandom, 4'($urandom_range(0, 15)));
          end
        end
      end

      reset = rst_now;
      for (int i = 0; i < L; i++) begin
        if (has[i]) leader_req[i] = pend[i];
        else leader_req[i] = mk_req(1'b0, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      follower_rsp.read_data       = $urandom;
      follower_rsp.read_data_valid = 1'b0;

      if (rst_now) begin
        // Any pending read is abandoned; a stray valid here must not surface
        if ($urandom_range(0, 3) == 0) follower_rsp.read_data_valid = 1'b1;
        busy = 1'b0;
        nxt  = 0;
      end else if (busy) begin
        waited++;
        if (waited == lat) begin
          follower_rsp.read_data_valid = 1'b1;
          rq.push_back('{cyc, owner, follower_rsp.read_data, 1'b0});
          busy = 1'b0;
        end else if (waited == TO) begin
          rq.push_back('{cyc, owner, 32'hDEAD_BEEF, 1'b1});
          busy = 1'b0;
        end
      end else begin
        // Late/stray follower valid while the bus is free must be dropped
        if ($urandom_range(0, 5) == 0) follower_rsp.read_data_valid = 1'b1;
        w = -1;
        for (int k = 0; k < L; k++) begin
          j = (nxt + k) % L;
          if (w < 0 && has[j]) w = j;
        end
        if (w >= 0) begin
          e = pend[w];
          if (e.write_req) e.read_req = 1'b0;
          xq.push_back('{cyc, w, e});
          has[w] = 1'b0;
          nxt    = (w + 1) % L;
          if (!pend[w].write_req) begin
            busy   = 1'b1;
            owner  = w;
            waited = 0;
            lat    = int'($urandom_range(1, TO + 1));
          end
        end
      end
    end

    @(negedge clk);
    #1;
    while (xq.size() > 0) begin
      note_fail("xfer_missing", "no transfer", $sformatf("grant to leader %0d", xq[0].ldr));
      void'(xq.pop_front());
    end
    while (rq.size() > 0) begin
      note_fail("rsp_missing", "no response", $sformatf("valid to leader %0d", rq[0].ldr));
      void'(rq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
